// File: rtl/rsv_mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single-outstanding shared memory port.
// Data has priority; fetch wins once data has been granted STARVE_LIMIT times in a row.
module rsv_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  output logic        fetch_gnt_o,
  output logic        fetch_rvalid_o,
  output logic [31:0] fetch_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        owner_q;          // 1 = fetch owns the port, 0 = data
  logic        armed_q;
  logic [3:0]  starve_q, starve_d;
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:0] lat_addr, lat_wdata;

  logic resp, can_issue, pick_fetch, cur_fetch;

  always_comb begin
    resp        = (state_q == RESP) && mem_rvalid_i;
    can_issue   = armed_q && ((state_q == IDLE) || resp);
    pick_fetch  = fetch_req_i && (!data_req_i || (starve_q == LIMIT));
    cur_fetch   = owner_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    // REQ replays the latched request so the port cannot change while stalled;
    // a fresh request is driven straight from the winner's inputs.
    if (state_q == REQ) begin
      mem_req_o   = 1'b1;
      mem_we_o    = lat_we;
      mem_be_o    = lat_be;
      mem_addr_o  = lat_addr;
      mem_wdata_o = lat_wdata;
    end else if (can_issue && (fetch_req_i || data_req_i)) begin
      mem_req_o   = 1'b1;
      cur_fetch   = pick_fetch;
      if (pick_fetch) begin
        mem_addr_o  = fetch_addr_i;
      end else begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end
    end

    fetch_gnt_o    = mem_req_o && mem_gnt_i && cur_fetch;
    data_gnt_o     = mem_req_o && mem_gnt_i && !cur_fetch;
    fetch_rvalid_o = resp && owner_q;
    data_rvalid_o  = resp && !owner_q;
    fetch_rdata_o  = fetch_rvalid_o ? mem_rdata_i : '0;
    data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;

    state_d = state_q;
    if (resp) state_d = IDLE;
    if (mem_req_o) state_d = mem_gnt_i ? RESP : REQ;

    starve_d = starve_q;
    if (!fetch_req_i || fetch_gnt_o) begin
      starve_d = '0;
    end else if (data_gnt_o && (starve_q < LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      armed_q   <= 1'b0;
      starve_q  <= '0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state_q  <= state_d;
      armed_q  <= 1'b1;
      starve_q <= starve_d;
      if (mem_req_o) begin
        owner_q   <= cur_fetch;
        lat_we    <= mem_we_o;
        lat_be    <= mem_be_o;
        lat_addr  <= mem_addr_o;
        lat_wdata <= mem_wdata_o;
      end
    end
  end

endmodule

// File: tb/tb_rsv_mem_arbiter.sv
// Directed bench for rsv_mem_arbiter: a transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_rsv_mem_arbiter;

  localparam int unsigned LIM = 4;

  logic        clk;
  logic        reset_n;
  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_gnt_o, fetch_rvalid_o;
  logic [31:0] fetch_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  rsv_mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
    .fetch_gnt_o(fetch_gnt_o), .fetch_rvalid_o(fetch_rvalid_o), .fetch_rdata_o(fetch_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: is a transaction in flight, is one stalled awaiting gnt, who owns it.
  logic        m_ready;
  logic        m_inflight;
  logic        m_stalled;
  logic        m_fetch_owns;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wd;
  int          m_data_streak;

  logic        e_req, e_fetch, e_we, e_fg, e_dg, e_fv, e_dv, e_done, e_free;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wd;

  logic        rec = 1'b0;
  logic        g_seen = 1'b0;
  logic [9:0]  gseq = '0;
  int          gcount = 0;

  always @(negedge clk) begin
    e_req = 1'b0; e_fetch = 1'b0; e_we = 1'b0; e_be = '0; e_addr = '0; e_wd = '0;
    e_fg = 1'b0; e_dg = 1'b0; e_fv = 1'b0; e_dv = 1'b0; e_done = 1'b0; e_free = 1'b0;
    if (!reset_n) begin
      m_ready = 1'b0; m_inflight = 1'b0; m_stalled = 1'b0; m_fetch_owns = 1'b0;
      m_we = 1'b0; m_be = '0; m_addr = '0; m_wd = '0; m_data_streak = 0;
    end else begin
      e_done = m_inflight && mem_rvalid_i;
      e_free = m_ready && !m_stalled && (!m_inflight || e_done);
      if (m_stalled) begin
        e_req = 1'b1; e_fetch = m_fetch_owns;
        e_we = m_we; e_be = m_be; e_addr = m_addr; e_wd = m_wd;
      end else if (e_free && (fetch_req_i || data_req_i)) begin
        e_req   = 1'b1;
        e_fetch = fetch_req_i && (!data_req_i || m_data_streak == LIM);
        if (e_fetch) e_addr = fetch_addr_i;
        else begin
          e_we = data_we_i; e_be = data_be_i; e_addr = data_addr_i; e_wd = data_wdata_i;
        end
      end
      e_fg = e_req && mem_gnt_i && e_fetch;
      e_dg = e_req && mem_gnt_i && !e_fetch;
      e_fv = e_done && m_fetch_owns;
      e_dv = e_done && !m_fetch_owns;
    end

    chk("mem_req", 32'(mem_req_o), 32'(e_req));
    chk("mem_we", 32'(mem_we_o), 32'(e_we));
    chk("mem_be", 32'(mem_be_o), 32'(e_be));
    chk("mem_addr", mem_addr_o, e_addr);
    chk("mem_wdata", mem_wdata_o, e_wd);
    chk("fetch_gnt", 32'(fetch_gnt_o), 32'(e_fg));
    chk("data_gnt", 32'(data_gnt_o), 32'(e_dg));
    chk("fetch_rvalid", 32'(fetch_rvalid_o), 32'(e_fv));
    chk("data_rvalid", 32'(data_rvalid_o), 32'(e_dv));
    chk("fetch_rdata", fetch_rdata_o, e_fv ? mem_rdata_i : 32'h0);
    chk("data_rdata", data_rdata_o, e_dv ? mem_rdata_i : 32'h0);

    g_seen = mem_req_o && mem_gnt_i;
    if (rec && (fetch_gnt_o || data_gnt_o)) begin
      gseq = {gseq[8:0], fetch_gnt_o};
      gcount++;
    end

    if (reset_n) begin
      if (e_done) m_inflight = 1'b0;
      if (e_req) begin
        m_fetch_owns = e_fetch;
        m_we = e_we; m_be = e_be; m_addr = e_addr; m_wd = e_wd;
        m_inflight = mem_gnt_i;
        m_stalled  = !mem_gnt_i;
      end
      if (!fetch_req_i || e_fg) m_data_streak = 0;
      else if (e_dg && m_data_streak < LIM) m_data_streak++;
      m_ready = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    fetch_req_i = 1'b0; fetch_addr_i = '0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'hF;
    data_addr_i = '0; data_wdata_i = 32'hFFFF_FFFF;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    cyc(); cyc();
    settle();
    chk("reset_mem_req", 32'(mem_req_o), 32'h0);
    chk("reset_data_rvalid", 32'(data_rvalid_o), 32'h0);

    // Fetch only; first cycle after release must stay quiet.
    cyc();
    reset_n = 1'b1; fetch_req_i = 1'b1; fetch_addr_i = 32'h100; mem_gnt_i = 1'b1;
    settle();
    chk("first_cycle_no_req", 32'(mem_req_o), 32'h0);
    cyc();
    settle();
    chk("fetch_gnt", 32'(fetch_gnt_o), 32'h1);
    chk("fetch_addr", mem_addr_o, 32'h100);
    chk("fetch_wdata_masked", mem_wdata_o, 32'h0);
    chk("fetch_be_masked", 32'(mem_be_o), 32'h0);
    cyc();
    fetch_req_i = 1'b0; mem_gnt_i = 1'b0;
    cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013;
    settle();
    chk("fetch_rvalid", 32'(fetch_rvalid_o), 32'h1);
    chk("fetch_rdata", fetch_rdata_o, 32'h0000_0013);
    chk("fetch_rv_data_quiet", 32'(data_rvalid_o), 32'h0);
    cyc();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    settle();
    chk("fetch_rvalid_pulse", 32'(fetch_rvalid_o), 32'h0);

    // Simultaneous requests: data first, fetch granted on the data rvalid cycle.
    cyc();
    fetch_req_i = 1'b1; fetch_addr_i = 32'h104;
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h2000; mem_gnt_i = 1'b1;
    settle();
    chk("both_data_wins", 32'(data_gnt_o), 32'h1);
    chk("both_fetch_waits", 32'(fetch_gnt_o), 32'h0);
    cyc();
    data_req_i = 1'b0;
    settle();
    chk("resp_no_fetch_gnt", 32'(fetch_gnt_o), 32'h0);
    cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    settle();
    chk("load_rvalid", 32'(data_rvalid_o), 32'h1);
    chk("load_rdata", data_rdata_o, 32'hCAFE_F00D);
    chk("fetch_gnt_b2b", 32'(fetch_gnt_o), 32'h1);
    cyc();
    fetch_req_i = 1'b0; mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
    cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0093;
    settle();
    chk("fetch2_rvalid", 32'(fetch_rvalid_o), 32'h1);
    cyc();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    // Both held continuously: expect D,D,D,D,F then again D,D,D,D,F.
    cyc();
    fetch_req_i = 1'b1; fetch_addr_i = 32'h200;
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h4000; mem_gnt_i = 1'b1;
    rec = 1'b1;
    for (int k = 0; k < 40 && gcount < 10; k++) begin
      cyc();
      mem_rvalid_i = g_seen;
      mem_rdata_i = 32'h1000 + 32'(k);
    end
    fetch_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0;
    rec = 1'b0;
    chk("starve_grant_count", 32'(gcount), 32'd10);
    chk("starve_sequence", 32'(gseq), 32'(10'b00001_00001));
    cyc();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    // Store stalled by memory for three cycles.
    cyc();
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF;
    data_addr_i = 32'h3000; data_wdata_i = 32'hDEAD_BEEF; mem_gnt_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_gnt_i = 1'b1;
      settle();
      chk("store_addr_stable", mem_addr_o, 32'h3000);
      chk("store_wdata_stable", mem_wdata_o, 32'hDEAD_BEEF);
      chk("store_we_be", {27'h0, mem_we_o, mem_be_o}, 32'h1F);
      chk("store_gnt", 32'(data_gnt_o), (k == 3) ? 32'h1 : 32'h0);
      cyc();
    end
    data_req_i = 1'b0; mem_gnt_i = 1'b0;
    settle();
    chk("store_gnt_single", 32'(data_gnt_o), 32'h0);
    cyc();
    mem_rvalid_i = 1'b1;
    settle();
    chk("store_done", 32'(data_rvalid_o), 32'h1);
    cyc();
    mem_rvalid_i = 1'b0; data_we_i = 1'b0;

    // Reset while a fetch is outstanding; its late response must be dropped.
    cyc();
    fetch_req_i = 1'b1; fetch_addr_i = 32'h300; mem_gnt_i = 1'b1;
    settle();
    chk("pre_reset_gnt", 32'(fetch_gnt_o), 32'h1);
    cyc();
    fetch_req_i = 1'b0; mem_gnt_i = 1'b0;
    settle();
    reset_n = 1'b0;
    settle();
    chk("async_reset_req", 32'(mem_req_o), 32'h0);
    chk("async_reset_addr", mem_addr_o, 32'h0);
    cyc();
    reset_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5151_5151;
    settle();
    chk("stale_rv_fetch", 32'(fetch_rvalid_o), 32'h0);
    cyc();
    settle();
    chk("stale_rv_fetch2", 32'(fetch_rvalid_o), 32'h0);
    chk("stale_rv_data", 32'(data_rvalid_o), 32'h0);
    cyc();
    mem_rvalid_i = 1'b0;

    // Spurious rvalid in IDLE, then a normal store proves the arbiter stayed idle.
    cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
    settle();
    chk("spurious_rv", {30'h0, fetch_rvalid_o, data_rvalid_o}, 32'h0);
    cyc();
    mem_rvalid_i = 1'b0;
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3;
    data_addr_i = 32'h5000; data_wdata_i = 32'h1234; mem_gnt_i = 1'b1;
    settle();
    chk("post_spurious_gnt", 32'(data_gnt_o), 32'h1);
    chk("post_spurious_be", 32'(mem_be_o), 32'h3);
    cyc();
    data_req_i = 1'b0; mem_gnt_i = 1'b0;
    cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
    settle();
    chk("post_spurious_done", data_rdata_o, 32'h55);
    cyc();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
